core_dbus_wb_bridge: RTL

Bridges the rv32i core's MEM-stage data port to a Wishbone classic (B4, non-pipelined) master bus. Sits directly downstream of the core: consumes `mem_addr_mem`/`mem_wdata_mem`/`mem_write_mem`/`mem_read_mem`/`mem_op_mem`, returns `mem_rdata_mem`, and produces the `stall_pipl` that freezes the pipeline while a bus cycle is outstanding. Performs byte-lane steering, load sign/zero extension, alignment checking and an ack timeout.

---
 rtl/core_dbus_wb_bridge.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/core_dbus_wb_bridge.sv
// MEM-stage data port to Wishbone classic master bridge.
// Handles byte-lane steering, load extension, alignment checks and an ack timeout.
module core_dbus_wb_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] mem_addr_mem,
    input  logic [31:0] mem_wdata_mem,
    input  logic        mem_write_mem,
    input  logic        mem_read_mem,
    input  logic [2:0]  mem_op_mem,
    output logic [31:0] mem_rdata_mem,
    output logic        stall_pipl,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        bus_err_o,
    output logic [1:0]  bus_err_cause_o
);

    // state | meaning
    // IDLE  | waiting for a load/store request from the core
    // BUSY  | Wishbone cycle outstanding, waiting for ack/err/timeout
    // DONE  | one-cycle completion: stall released, data/error valid
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state;
    logic [1:0]  lat_off;
    logic [2:0]  lat_op;
    logic        lat_we;
    logic [15:0] to_cnt;
    logic [31:0] rdata_q;
    logic [1:0]  cause_q;
    logic        err_q;

    logic        req;
    logic        illegal_op;
    logic        misaligned;
    logic [31:0] st_dat;
    logic [3:0]  st_sel;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [15:0] to_inc;
    logic        timed_out;

    assign req        = mem_write_mem | mem_read_mem;
    assign illegal_op = (mem_op_mem == 3'b011) | (mem_op_mem[2] & mem_op_mem[1]);
    assign misaligned = ((mem_op_mem[1:0] == 2'b01) & mem_addr_mem[0]) |
                        ((mem_op_mem[1:0] == 2'b10) & (mem_addr_mem[1:0] != 2'b00));

    always_comb begin
        st_dat = mem_wdata_mem;
        st_sel = 4'b1111;
        case (mem_op_mem[1:0])
            2'b00: begin
                st_dat = {4{mem_wdata_mem[7:0]}};
                st_sel = 4'b0001 << mem_addr_mem[1:0];
            end
            2'b01: begin
                st_dat = {2{mem_wdata_mem[15:0]}};
                st_sel = mem_addr_mem[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_dat = mem_wdata_mem;
                st_sel = 4'b1111;
            end
        endcase
    end

    always_comb begin
        ld_byte = 8'h00;
        case (lat_off)
            2'd0:    ld_byte = wb_dat_i[7:0];
            2'd1:    ld_byte = wb_dat_i[15:8];
            2'd2:    ld_byte = wb_dat_i[23:16];
            default: ld_byte = wb_dat_i[31:24];
        endcase
        ld_half = lat_off[1] ? wb_dat_i[31:16] : wb_dat_i[15:0];
        case (lat_op)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = wb_dat_i;
        endcase
    end

    assign to_inc    = (to_cnt == 16'hFFFF) ? to_cnt : to_cnt + 16'd1;
    assign timed_out = (to_inc >= TO_LIMIT);

    // Gated by reset so the freeze releases immediately while reset is held.
    assign stall_pipl = reset_n & (((state == IDLE) & req) | (state == BUSY));

    assign mem_rdata_mem   = rdata_q;
    assign bus_err_o       = err_q;
    assign bus_err_cause_o = cause_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            lat_off  <= 2'b00;
            lat_op   <= 3'b000;
            lat_we   <= 1'b0;
            to_cnt   <= 16'h0;
            rdata_q  <= 32'h0;
            cause_q  <= 2'b00;
            err_q    <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= 32'h0;
            wb_dat_o <= 32'h0;
            wb_sel_o <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_off <= mem_addr_mem[1:0];
                        lat_op  <= mem_op_mem;
                        lat_we  <= mem_write_mem;
                        if (illegal_op | misaligned) begin
                            state   <= DONE;
                            cause_q <= 2'b11;
                            err_q   <= 1'b1;
                            if (!mem_write_mem) rdata_q <= 32'h0;
                        end else begin
                            state    <= BUSY;
                            to_cnt   <= 16'h0;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_we_o  <= mem_write_mem;
                            wb_adr_o <= {mem_addr_mem[31:2], 2'b00};
                            wb_dat_o <= st_dat;
                            wb_sel_o <= st_sel;
                        end
                    end
                end
                BUSY: begin
                    if (wb_err_i | wb_ack_i | timed_out) begin
                        state    <= DONE;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_adr_o <= 32'h0;
                        wb_dat_o <= 32'h0;
                        wb_sel_o <= 4'h0;
                        // err beats ack, ack beats a timeout landing on the same cycle
                        if (wb_err_i) begin
                            cause_q <= 2'b01;
                            err_q   <= 1'b1;
                            if (!lat_we) rdata_q <= 32'h0;
                        end else if (wb_ack_i) begin
                            if (!lat_we) rdata_q <= ld_data;
                        end else begin
                            cause_q <= 2'b10;
                            err_q   <= 1'b1;
                            if (!lat_we) rdata_q <= 32'h0;
                        end
                    end else begin
                        to_cnt <= to_inc;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    cause_q <= 2'b00;
                    err_q   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
